// File: rtl/rx_unit_pkg.sv
// Shared definitions for the MiniUart receive unit: FSM encodings,
// default oversample ratio and data width.
package rx_unit_pkg;

  localparam int DATA_W  = 8;
  localparam int OSR_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage : rx_unit_pkg

// File: rtl/rx_unit_rcv_reg.sv
// Receive shift register: serial-in (LSB first, entering at bit 7 and
// shifting right) plus the host-visible holding register for d_out.
module rx_unit_rcv_reg
  import rx_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en_i,
  input  logic              bit_i,
  input  logic              load_en_i,
  output logic [DATA_W-1:0] d_out_o
);

  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] shift_d;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;

  // Next value of the shift and holding registers.
  always_comb begin
    shift_d = shift_q;
    hold_d  = hold_q;
    if (shift_en_i) begin
      shift_d = {bit_i, shift_q[DATA_W-1:1]};
    end else begin
      shift_d = shift_q;
    end
    if (load_en_i) begin
      hold_d = shift_q;
    end else begin
      hold_d = hold_q;
    end
  end

  // Shift and holding registers; reset discards any partial byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= {DATA_W{1'b0}};
      hold_q  <= {DATA_W{1'b0}};
    end else begin
      shift_q <= shift_d;
      hold_q  <= hold_d;
    end
  end

  assign d_out_o = hold_q;

endmodule : rx_unit_rcv_reg

// File: rtl/rx_unit.sv
// MiniUart receive unit: synchronises rxd, finds the start bit, samples
// each bit at mid-bit on the OSR x baud tick, and reports the byte with
// receive-status, framing-error and overrun flags.
module rx_unit
  import rx_unit_pkg::*;
#(
  parameter int OSR         = OSR_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  input  logic              en_rx,
  input  logic              read,
  output logic [DATA_W-1:0] d_out,
  output logic              rs,
  output logic              fe,
  output logic              oe
);

  localparam int             TW        = $clog2(OSR);
  localparam logic [TW-1:0]  TICK_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0]  TICK_ONE  = TW'(1);
  localparam logic [TW-1:0]  TICK_MID  = TW'(OSR / 2);
  localparam logic [TW-1:0]  TICK_LAST = TW'(OSR - 1);
  localparam logic [2:0]     BIT_LAST  = 3'd7;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs_s;

  rx_state_e    state_q;
  rx_state_e    state_d;
  logic [TW-1:0] tick_q;
  logic [TW-1:0] tick_d;
  logic [2:0]   bit_q;
  logic [2:0]   bit_d;
  logic         brk_q;
  logic         brk_d;
  logic         shift_en_s;
  logic         done_s;

  logic         rs_q;
  logic         rs_d;
  logic         fe_q;
  logic         fe_d;
  logic         oe_q;
  logic         oe_d;

  // Metastability chain for the asynchronous serial line; idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
    end
  end

  assign rxs_s = sync_q[SYNC_STAGES-1];

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; transitions happen only on oversample ticks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_rx && !brk_q && !rxs_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (en_rx && (tick_q == TICK_MID)) begin
          state_d = rxs_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (en_rx && (tick_q == TICK_LAST) && (bit_q == BIT_LAST)) begin
          state_d = ST_STOP;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (en_rx && (tick_q == TICK_LAST)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: counter updates, shift strobe, byte-complete strobe and
  // the break guard that blocks retriggering on a line stuck low.
  always_comb begin
    tick_d     = tick_q;
    bit_d      = bit_q;
    brk_d      = brk_q;
    shift_en_s = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_rx && brk_q && rxs_s) begin
          brk_d = 1'b0;
        end else if (en_rx && !brk_q && !rxs_s) begin
          tick_d = TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      ST_START: begin
        if (en_rx && (tick_q == TICK_MID)) begin
          tick_d = TICK_ZERO;
          bit_d  = 3'd0;
        end else if (en_rx) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      ST_DATA: begin
        if (en_rx && (tick_q == TICK_LAST)) begin
          tick_d     = TICK_ZERO;
          bit_d      = bit_q + 3'd1;
          shift_en_s = 1'b1;
        end else if (en_rx) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      ST_STOP: begin
        if (en_rx && (tick_q == TICK_LAST)) begin
          tick_d = TICK_ZERO;
          done_s = 1'b1;
          brk_d  = ~rxs_s;
        end else if (en_rx) begin
          tick_d = tick_q + TICK_ONE;
        end else begin
          tick_d = tick_q;
        end
      end
      default: begin
        tick_d = TICK_ZERO;
        bit_d  = 3'd0;
        brk_d  = 1'b0;
      end
    endcase
  end

  // Tick/bit counters and break guard.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q <= TICK_ZERO;
      bit_q  <= 3'd0;
      brk_q  <= 1'b0;
    end else begin
      tick_q <= tick_d;
      bit_q  <= bit_d;
      brk_q  <= brk_d;
    end
  end

  // Host flags: a completing byte beats a simultaneous read; overrun is
  // raised only when an unread byte is overwritten.
  always_comb begin
    rs_d = rs_q;
    fe_d = fe_q;
    oe_d = oe_q;
    if (done_s) begin
      rs_d = 1'b1;
      fe_d = ~rxs_s;
      oe_d = rs_q & ~read;
    end else if (read) begin
      rs_d = 1'b0;
      fe_d = 1'b0;
      oe_d = 1'b0;
    end else begin
      rs_d = rs_q;
      fe_d = fe_q;
      oe_d = oe_q;
    end
  end

  // Host flag registers; sticky until read or reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rs_q <= 1'b0;
      fe_q <= 1'b0;
      oe_q <= 1'b0;
    end else begin
      rs_q <= rs_d;
      fe_q <= fe_d;
      oe_q <= oe_d;
    end
  end

  rx_unit_rcv_reg u_rcv_reg (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en_s),
    .bit_i      (rxs_s),
    .load_en_i  (done_s),
    .d_out_o    (d_out)
  );

  assign rs = rs_q;
  assign fe = fe_q;
  assign oe = oe_q;

endmodule : rx_unit

// File: tb/tb_rx_unit.sv
// Directed testbench for rx_unit: drives whole serial frames and checks
// the received byte and host flags against hand-computed values.
module tb_rx_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       en_rx;
  logic       read;
  logic [7:0] d_out;
  logic       rs;
  logic       fe;
  logic       oe;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rx_unit #(.OSR(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .rxd   (rxd),
    .en_rx (en_rx),
    .read  (read),
    .d_out (d_out),
    .rs    (rs),
    .fe    (fe),
    .oe    (oe)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] data, input logic stop, input int b);
    if (b == 0) return 1'b0;
    else if (b == 9) return stop;
    else return data[b-1];
  endfunction

  task automatic idle_line(input int n);
    rxd   = 1'b1;
    en_rx = 1'b1;
    read  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_read();
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
  endtask

  // One full frame, cpb clocks per bit; read is raised on frame clock
  // read_cyc (-1 = never); half selects en_rx on every other clock.
  task automatic send_frame(input logic [7:0] data, input logic stop, input int cpb,
                            input bit half, input int read_cyc);
    int b;
    for (int i = 0; i < 10 * cpb; i++) begin
      b = i / cpb;
      @(negedge clk);
      rxd   = frame_bit(data, stop, b);
      read  = (i == read_cyc);
      en_rx = half ? (i % 2 == 0) : 1'b1;
    end
    read  = 1'b0;
    en_rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    rxd   = 1'b1;
    en_rx = 1'b1;
    read  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", d_out, 8'h00);
    check_eq("rst_rs", {7'd0, rs}, 8'h00);
    check_eq("rst_fe", {7'd0, fe}, 8'h00);
    check_eq("rst_oe", {7'd0, oe}, 8'h00);
    rst = 1'b1;
    idle_line(20);

    // Clean frame 0xA5.
    send_frame(8'hA5, 1'b1, 16, 1'b0, -1);
    check_eq("a5_dout", d_out, 8'hA5);
    check_eq("a5_rs", {7'd0, rs}, 8'h01);
    check_eq("a5_fe", {7'd0, fe}, 8'h00);
    check_eq("a5_oe", {7'd0, oe}, 8'h00);
    pulse_read();
    check_eq("a5_read_rs", {7'd0, rs}, 8'h00);

    // Start-bit glitch of 4 ticks: rejected, nothing changes.
    idle_line(10);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle_line(60);
    check_eq("glitch_rs", {7'd0, rs}, 8'h00);
    check_eq("glitch_fe", {7'd0, fe}, 8'h00);
    check_eq("glitch_dout", d_out, 8'hA5);

    // 0x3C with a low stop bit, then line held low (break) for 3 more bits.
    send_frame(8'h3C, 1'b0, 16, 1'b0, -1);
    check_eq("fe_dout", d_out, 8'h3C);
    check_eq("fe_rs", {7'd0, rs}, 8'h01);
    check_eq("fe_fe", {7'd0, fe}, 8'h01);
    check_eq("fe_oe", {7'd0, oe}, 8'h00);
    rxd = 1'b0;
    repeat (48) @(negedge clk);
    idle_line(200);
    check_eq("brk_dout", d_out, 8'h3C);
    check_eq("brk_rs", {7'd0, rs}, 8'h01);
    check_eq("brk_oe", {7'd0, oe}, 8'h00);
    pulse_read();
    check_eq("fe_read_fe", {7'd0, fe}, 8'h00);
    check_eq("fe_read_rs", {7'd0, rs}, 8'h00);

    // Back-to-back 0x11, 0x22 without read: overrun.
    idle_line(20);
    send_frame(8'h11, 1'b1, 16, 1'b0, -1);
    send_frame(8'h22, 1'b1, 16, 1'b0, -1);
    check_eq("ovr_dout", d_out, 8'h22);
    check_eq("ovr_rs", {7'd0, rs}, 8'h01);
    check_eq("ovr_oe", {7'd0, oe}, 8'h01);
    check_eq("ovr_fe", {7'd0, fe}, 8'h00);
    pulse_read();
    check_eq("ovr_read_oe", {7'd0, oe}, 8'h00);

    // Same, with read on the completion clock of the second byte.
    // Completion edge: 2 sync + 1 detect + 8 half-bit + 9*16 = rising edge 155
    // of the frame, which follows the negedge at frame clock 154.
    idle_line(20);
    send_frame(8'h11, 1'b1, 16, 1'b0, -1);
    send_frame(8'h22, 1'b1, 16, 1'b0, 154);
    check_eq("rdc_dout", d_out, 8'h22);
    check_eq("rdc_rs", {7'd0, rs}, 8'h01);
    check_eq("rdc_oe", {7'd0, oe}, 8'h00);
    check_eq("rdc_fe", {7'd0, fe}, 8'h00);
    pulse_read();

    // Reset during data bit 4 of 0xFF, then a clean 0x5A.
    idle_line(20);
    for (int i = 0; i < 88; i++) begin
      @(negedge clk);
      rxd = frame_bit(8'hFF, 1'b1, i / 16);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("mrst_dout", d_out, 8'h00);
    check_eq("mrst_rs", {7'd0, rs}, 8'h00);
    rst = 1'b1;
    idle_line(20);
    send_frame(8'h5A, 1'b1, 16, 1'b0, -1);
    check_eq("mrst_5a_dout", d_out, 8'h5A);
    check_eq("mrst_5a_rs", {7'd0, rs}, 8'h01);
    check_eq("mrst_5a_fe", {7'd0, fe}, 8'h00);
    check_eq("mrst_5a_oe", {7'd0, oe}, 8'h00);
    pulse_read();

    // en_rx every other clock, 32 clocks per bit: counters gate on en_rx.
    idle_line(20);
    send_frame(8'hC3, 1'b1, 32, 1'b1, -1);
    idle_line(4);
    check_eq("half_dout", d_out, 8'hC3);
    check_eq("half_rs", {7'd0, rs}, 8'h01);
    check_eq("half_fe", {7'd0, fe}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rx_unit
